// File: rtl/blink_monitor_if.sv
// rtl/blink_monitor_if.sv - blink input and lock/period status bundle for blink_monitor
interface blink_monitor_if #(
  parameter int CNT_W = 16
);
  logic             blink_in;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             lost;

  modport master (input blink_in, output locked, period, period_valid, lost);
  modport slave  (output blink_in, input locked, period, period_valid, lost);
endinterface

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - blink half-period checker with lock/loss detection
// Optional 4-cycle glitch filter on the synchronized level: BLINK_MONITOR_GLITCH_FILTER_EN
module blink_monitor #(
  parameter int HALF_PERIOD = 25000,
  parameter int TOLERANCE   = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  blink_monitor_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(HALF_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] WIN_LO  =
    (HALF_PERIOD > TOLERANCE) ? CNT_W'(HALF_PERIOD - TOLERANCE) : '0;
  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;

  logic sync1, sync2;
  logic level_q;
  logic edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.blink_in;
      sync2 <= sync1;
    end
  end

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  logic [1:0] hold_cnt;

  // A new level is accepted only after it has differed from the held level for 4 cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= 1'b0;
      hold_cnt <= 2'd0;
      edge_q   <= 1'b0;
    end else begin
      edge_q <= 1'b0;
      if (sync2 == level_q) begin
        hold_cnt <= 2'd0;
      end else if (hold_cnt == 2'd3) begin
        level_q  <= sync2;
        hold_cnt <= 2'd0;
        edge_q   <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 2'd1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      level_q <= sync2;
      edge_q  <= sync2 ^ level_q;
    end
  end
`endif

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] interval;
  logic             in_window;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (edge_q) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign interval  = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign in_window = (interval >= WIN_LO) && (interval <= WIN_HI);
  // An edge landing in the timeout cycle is still measured as an edge
  assign timeout   = !edge_q && (cnt == WIN_HI);

  state_t           state, state_n;
  logic [7:0]       good_cnt, good_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic             pv_q, pv_n;
  logic             lost_q, lost_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      good_cnt <= 8'd0;
      period_q <= '0;
      pv_q     <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
      period_q <= period_n;
      pv_q     <= pv_n;
      lost_q   <= lost_n;
    end
  end

  always_comb begin
    state_n  = state;
    good_n   = good_cnt;
    period_n = period_q;
    pv_n     = 1'b0;
    lost_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (edge_q) begin
          state_n = S_ACQUIRE;
          good_n  = 8'd0;
        end
      end
      S_ACQUIRE: begin
        if (edge_q) begin
          period_n = interval;
          pv_n     = 1'b1;
          if (in_window) begin
            good_n = good_cnt + 8'd1;
            if (good_n == LOCK_N) state_n = S_LOCKED;
          end else begin
            good_n = 8'd0;
          end
        end else if (timeout) begin
          state_n = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (edge_q) begin
          period_n = interval;
          pv_n     = 1'b1;
          if (!in_window) begin
            state_n = S_ACQUIRE;
            good_n  = 8'd0;
            lost_n  = 1'b1;
          end
        end else if (timeout) begin
          state_n = S_IDLE;
          lost_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.locked       = (state == S_LOCKED);
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.lost         = lost_q;
endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - scoreboard bench for blink_monitor against an interval-rule model
`timescale 1ns/1ps
module tb_blink_monitor;
  localparam int HP    = 10;
  localparam int TOL   = 1;
  localparam int LOCKN = 3;
  localparam int W     = 8;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int TMO = HP + TOL + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  blink_monitor_if #(.CNT_W(W)) bus ();

  blink_monitor #(
    .HALF_PERIOD(HP),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LOCKN),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    bit pv;
    int per;
    bit lost;
    bit lck;
  } ev_t;
  ev_t exp_q[$];

  bit m_ref  = 0;
  bit m_lock = 0;
  int m_good = 0;
  int m_last = 0;
  int m_per  = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle(string name);
    chk({name, "_locked"}, int'(bus.locked), 0);
    chk({name, "_period"}, int'(bus.period), 0);
    chk({name, "_pv"}, int'(bus.period_valid), 0);
    chk({name, "_lost"}, int'(bus.lost), 0);
  endtask

  // No edge for more than HP+TOL+1 cycles: the reference is dropped, lock loss is reported
  task automatic model_timeout();
    if (m_ref) begin
      if (m_lock) exp_q.push_back('{m_last + LAT + TMO, 1'b0, m_per, 1'b1, 1'b0});
      m_ref  = 0;
      m_lock = 0;
      m_good = 0;
    end
  endtask

  task automatic model_edge(int k);
    int iv;
    bit inw;
    bit lst;
    if (m_ref && (k - m_last) > TMO) model_timeout();
    if (!m_ref) begin
      m_ref  = 1;
      m_good = 0;
    end else begin
      iv    = k - m_last;
      inw   = (iv >= HP - TOL) && (iv <= HP + TOL);
      lst   = 0;
      m_per = iv;
      if (m_lock) begin
        if (!inw) begin
          m_lock = 0;
          m_good = 0;
          lst    = 1;
        end
      end else if (inw) begin
        m_good++;
        if (m_good == LOCKN) m_lock = 1;
      end else begin
        m_good = 0;
      end
      exp_q.push_back('{k + LAT, 1'b1, iv, lst, m_lock});
    end
    m_last = k;
  endtask

  // Called at a negedge; toggles blink_in n negedges later, first sampled at the following posedge
  task automatic step(int n);
    model_edge(cyc + n + 1);
    repeat (n) @(negedge clk);
    bus.blink_in = ~bus.blink_in;
  endtask

  task automatic idle(int n);
    model_timeout();
    repeat (n) @(negedge clk);
  endtask

  function automatic int rand_gap();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(HP - TOL, HP + TOL));
    if (r < 8) return int'($urandom_range(5, TMO + 1));
    if (r == 8) return ($urandom_range(0, 1) != 0) ? (HP - TOL - 1) : TMO;
    return int'($urandom_range(TMO + 2, 25));
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      while (exp_q.size() != 0 && exp_q[0].t < cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_event: nothing seen, expected pv=%0d period=%0d lost=%0d at cycle %0d",
                 e.pv, e.per, e.lost, e.t);
      end
      if (bus.period_valid || bus.lost) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got pv=%0d period=%0d lost=%0d, expected none (cycle %0d)",
                   bus.period_valid, bus.period, bus.lost, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.t);
          chk("period_valid", int'(bus.period_valid), int'(e.pv));
          chk("period", int'(bus.period), e.per);
          chk("lost", int'(bus.lost), int'(e.lost));
          chk("locked", int'(bus.locked), int'(e.lck));
        end
      end
    end
  end

  initial begin
    bus.blink_in = 1'b0;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_idle("reset_hold");
      bus.blink_in = ~bus.blink_in;
    end
    bus.blink_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk_idle("static_after_reset");

    repeat (4) step(10);
    step(12);
    repeat (3) step(10);
    step(13);
    repeat (3) step(10);
    idle(30);

    step(10);
    step(9); step(11); step(11);
    idle(30);
    step(10);
    step(10); step(12); step(10); step(10); step(10);
    idle(30);
    step(10);
    step(8); step(10); step(10); step(10);

    repeat (150) step(rand_gap());

    repeat (5) step(10);
    repeat (LAT + 5) @(negedge clk);
    chk("pre_reset_locked", int'(bus.locked), int'(m_lock));
    chk("pre_reset_queue", exp_q.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("mid_lock_reset");
    reset = 1'b0;
    m_ref = 0; m_lock = 0; m_good = 0; m_per = 0;
    if (bus.blink_in) model_edge(cyc + 1);
    repeat (LAT + 2) @(negedge clk);
    chk("post_reset_locked", int'(bus.locked), 0);
    chk("post_reset_period", int'(bus.period), 0);

    idle(30);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    bus.blink_in = ~bus.blink_in;
    repeat (2) @(negedge clk);
    bus.blink_in = ~bus.blink_in;
`else
    step(1);
    step(2);
`endif
    idle(30);
    chk("glitch_period_hold", int'(bus.locked), 0);
    repeat (4) step(10);

    idle(40);
    chk("final_locked", int'(bus.locked), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
